regfile_wb_arbiter: RTL

//  Write-side driver for the 32x32 register file. Arbitrates writeback requests

---
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-side driver for the register file: round-robin arbiter, FIFO and WE3/A3/WD3 drive.
// Optional read-forwarding over uncommitted writes when WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [AW-1:0]        s0_addr,
    input  logic signed [DW-1:0] s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [AW-1:0]        s1_addr,
    input  logic signed [DW-1:0] s1_data,
    output logic                 wb_we,
    output logic [AW-1:0]        wb_addr,
    output logic signed [DW-1:0] wb_data,
    output logic                 pending
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]        rd_a1,
    input  logic [AW-1:0]        rd_a2,
    input  logic [DW-1:0]        rf_rd1,
    input  logic [DW-1:0]        rf_rd2,
    output logic [DW-1:0]        fwd_rd1,
    output logic [DW-1:0]        fwd_rd2
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]        mem_addr [DEPTH];
    logic signed [DW-1:0] mem_data [DEPTH];

    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]          count_reg;
    logic                 last_grant_reg;   // 1 = src1 was granted last
    logic                 wb_we_reg;
    logic [AW-1:0]        wb_addr_reg;
    logic signed [DW-1:0] wb_data_reg;

    logic                 full, empty, grant0, grant1, accept, push, pop;
    logic [AW-1:0]        acc_addr;
    logic signed [DW-1:0] acc_data;

    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // A lone requester always wins; contention goes to the source not served last.
    assign grant0 = s0_valid & (~s1_valid | last_grant_reg);
    assign grant1 = s1_valid & ~grant0;

    assign s0_ready = grant0 & ~full;
    assign s1_ready = grant1 & ~full;

    assign accept   = s0_ready | s1_ready;
    assign acc_addr = s0_ready ? s0_addr : s1_addr;
    assign acc_data = s0_ready ? s0_data : s1_data;
    // Writes to x0 are acknowledged but dropped.
    assign push     = accept & (acc_addr != '0);
    assign pop      = ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_reg] <= acc_addr;
            mem_data[wr_ptr_reg] <= acc_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            last_grant_reg <= 1'b1;
            wb_we_reg      <= 1'b0;
            wb_addr_reg    <= '0;
            wb_data_reg    <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
            if (accept)
                last_grant_reg <= s1_ready;
            wb_we_reg <= pop;
            if (pop) begin
                wb_addr_reg <= mem_addr[rd_ptr_reg];
                wb_data_reg <= mem_data[rd_ptr_reg];
            end
        end
    end

    assign wb_we   = wb_we_reg;
    assign wb_addr = wb_addr_reg;
    assign wb_data = wb_data_reg;
    assign pending = ~empty | wb_we_reg;

`ifdef WB_BYPASS_EN
    // Entries viewed by age: index 0 is the oldest (next to commit).
    logic                 age_live [DEPTH];
    logic [AW-1:0]        age_addr [DEPTH];
    logic [DW-1:0]        age_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] idx;
            assign idx          = rd_ptr_reg + PW'(gi);
            assign age_live[gi] = ((PW+1)'(gi) < count_reg);
            assign age_addr[gi] = mem_addr[idx];
            assign age_data[gi] = mem_data[idx];
        end
    endgenerate

    // Later (younger) matches override earlier ones; x0 always reads zero.
    function automatic logic [DW-1:0] fwd_sel(input logic [AW-1:0] a, input logic [DW-1:0] rf);
        logic [DW-1:0] r;
        r = rf;
        if (wb_we_reg && (wb_addr_reg == a))
            r = wb_data_reg;
        for (int i = 0; i < DEPTH; i++)
            if (age_live[i] && (age_addr[i] == a))
                r = age_data[i];
        if (a == '0)
            r = '0;
        return r;
    endfunction

    assign fwd_rd1 = fwd_sel(rd_a1, rf_rd1);
    assign fwd_rd2 = fwd_sel(rd_a2, rf_rd2);
`endif

endmodule
